// File: rtl/seg_scan_capture.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_capture
// Description : Receive side of a multiplexed 7-segment display path.
//               Snoops an active-low segment/anode bus, waits for each digit
//               pattern to be stable, decodes it back to BCD and assembles
//               complete frames. Illegal segment patterns raise a sticky
//               error together with the offending digit index.
//
// Ports       : clk          system clock
//               rst_n        asynchronous active-low reset
//               seg_in[7:0]  segment bus, active-low, bit7 = dp, bits6:0 = g..a
//               an_in        anode selects, active-low, one-hot-low = valid
//               clr          synchronous clear of err/err_idx/seen/shadow
//               digits_out   last complete frame, digit i at [4i+3:4i]
//               dp_out       decimal points of last frame, 1 = lit
//               frame_valid  one-cycle pulse when digits_out/dp_out update
//               err          sticky illegal-pattern flag
//               err_idx      digit index of the most recent illegal sample
//
// Options     : SEG_SYNC_EN  when defined, a two-flop synchronizer is placed
//                            ahead of the input register so the bus may be
//                            asynchronous to clk (all latencies +2 cycles).
//
// Revision    : 1.0  initial release
// ============================================================================
module seg_scan_capture #(
    parameter int  NDIG       = 4,
    parameter int  STABLE_CYC = 16,
    parameter int  CNT_W      = 8,
    localparam int IDX_W      = (NDIG > 1) ? $clog2(NDIG) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          seg_in,
    input  logic [NDIG-1:0]     an_in,
    input  logic                clr,
    output logic [4*NDIG-1:0]   digits_out,
    output logic [NDIG-1:0]     dp_out,
    output logic                frame_valid,
    output logic                err,
    output logic [IDX_W-1:0]    err_idx
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(STABLE_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Input source (optionally synchronized)
    // ------------------------------------------------------------------
    logic [7:0]      w_seg_src;
    logic [NDIG-1:0] w_an_src;

`ifdef SEG_SYNC_EN
    logic [7:0]      r_seg_s1, r_seg_s2;
    logic [NDIG-1:0] r_an_s1,  r_an_s2;

    // Reset to all ones = blank display / no digit selected.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg_s1 <= '1;
            r_seg_s2 <= '1;
            r_an_s1  <= '1;
            r_an_s2  <= '1;
        end else begin
            r_seg_s1 <= seg_in;
            r_seg_s2 <= r_seg_s1;
            r_an_s1  <= an_in;
            r_an_s2  <= r_an_s1;
        end
    end

    assign w_seg_src = r_seg_s2;
    assign w_an_src  = r_an_s2;
`else
    assign w_seg_src = seg_in;
    assign w_an_src  = an_in;
`endif

    // ------------------------------------------------------------------
    // Input register and one-cycle-delayed copy for change detection
    // ------------------------------------------------------------------
    logic [7:0]      r_seg, r_seg_p;
    logic [NDIG-1:0] r_an,  r_an_p;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg   <= '1;
            r_an    <= '1;
            r_seg_p <= '1;
            r_an_p  <= '1;
        end else begin
            r_seg   <= w_seg_src;
            r_an    <= w_an_src;
            r_seg_p <= r_seg;
            r_an_p  <= r_an;
        end
    end

    logic            w_chg;
    logic [NDIG-1:0] w_an_act;
    logic            w_an_valid;
    logic [IDX_W-1:0] w_idx;

    assign w_chg      = ({r_seg, r_an} != {r_seg_p, r_an_p});
    assign w_an_act   = ~r_an;
    // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
    assign w_an_valid = (w_an_act != '0) &&
                        ((w_an_act & (w_an_act - NDIG'(1))) == '0);

    always_comb begin
        w_idx = '0;
        for (int k = 0; k < NDIG; k++) begin
            if (w_an_act[k]) w_idx = IDX_W'(k);
        end
    end

    // ------------------------------------------------------------------
    // Segment decode (exact match on g..a, dp handled separately)
    // ------------------------------------------------------------------
    logic       w_legal;
    logic [3:0] w_val;
    logic       w_dp;

    always_comb begin
        w_legal = 1'b1;
        w_val   = 4'd0;
        case (r_seg[6:0])
            7'h40:   w_val = 4'd0;
            7'h79:   w_val = 4'd1;
            7'h24:   w_val = 4'd2;
            7'h30:   w_val = 4'd3;
            7'h19:   w_val = 4'd4;
            7'h12:   w_val = 4'd5;
            7'h02:   w_val = 4'd6;
            7'h78:   w_val = 4'd7;
            7'h00:   w_val = 4'd8;
            7'h10:   w_val = 4'd9;
            default: w_legal = 1'b0;
        endcase
    end

    assign w_dp = ~r_seg[7];

    // ------------------------------------------------------------------
    // Stability FSM
    // ------------------------------------------------------------------
    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt,   w_cnt_nxt;
    logic             w_sample;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_sample    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (w_an_valid) w_state_nxt = S_COUNT;
            end
            S_COUNT: begin
                if (!w_an_valid) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else if (w_chg) begin
                    w_cnt_nxt   = '0;
                end else if (r_cnt >= c_CNT_MAX) begin
                    w_sample    = 1'b1;
                    w_state_nxt = S_HOLD;
                end else if (r_cnt != '1) begin
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                end
            end
            S_HOLD: begin
                // One sample per stable window; only a change re-arms.
                if (w_chg) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = w_an_valid ? S_COUNT : S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Shadow frame assembly
    // ------------------------------------------------------------------
    logic [4*NDIG-1:0] r_shadow,    w_shadow_nxt;
    logic [NDIG-1:0]   r_shadow_dp, w_sdp_nxt;
    logic [NDIG-1:0]   r_seen,      w_seen_nxt;
    logic [4*NDIG-1:0] r_digits;
    logic [NDIG-1:0]   r_dp;
    logic              r_frame_valid;
    logic              r_err;
    logic [IDX_W-1:0]  r_err_idx;

    // Shadow contents as they would look after merging the current sample,
    // so a completing sample can publish the frame in the same edge.
    always_comb begin
        w_shadow_nxt = r_shadow;
        w_sdp_nxt    = r_shadow_dp;
        w_seen_nxt   = r_seen | w_an_act;
        for (int k = 0; k < NDIG; k++) begin
            if (w_an_act[k]) begin
                w_shadow_nxt[4*k +: 4] = w_val;
                w_sdp_nxt[k]           = w_dp;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow      <= '0;
            r_shadow_dp   <= '0;
            r_seen        <= '0;
            r_digits      <= '0;
            r_dp          <= '0;
            r_frame_valid <= 1'b0;
            r_err         <= 1'b0;
            r_err_idx     <= '0;
        end else begin
            r_frame_valid <= 1'b0;
            if (clr) begin
                // clr outranks a coincident sample; published frame is kept.
                r_shadow    <= '0;
                r_shadow_dp <= '0;
                r_seen      <= '0;
                r_err       <= 1'b0;
                r_err_idx   <= '0;
            end else if (w_sample) begin
                if (w_legal) begin
                    r_shadow    <= w_shadow_nxt;
                    r_shadow_dp <= w_sdp_nxt;
                    if (&w_seen_nxt) begin
                        r_digits      <= w_shadow_nxt;
                        r_dp          <= w_sdp_nxt;
                        r_frame_valid <= 1'b1;
                        r_seen        <= '0;
                    end else begin
                        r_seen <= w_seen_nxt;
                    end
                end else begin
                    r_err     <= 1'b1;
                    r_err_idx <= w_idx;
                end
            end
        end
    end

    assign digits_out  = r_digits;
    assign dp_out      = r_dp;
    assign frame_valid = r_frame_valid;
    assign err         = r_err;
    assign err_idx     = r_err_idx;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_scan_capture
// Description : Self-checking bench for seg_scan_capture. Expected frames are
//               queued as digits are driven; a monitor captures every
//               frame_valid pulse and each scenario task compares the two.
// Revision    : 1.0  initial release
// ============================================================================
module tb_seg_scan_capture;

    localparam int NDIG = 4;
`ifdef SEG_SYNC_EN
    localparam int SYNC_ADD = 2;
`else
    localparam int SYNC_ADD = 0;
`endif
    // Drive edge of the last digit to visible frame_valid.
    localparam int FRAME_LAT  = 18 + SYNC_ADD;
    // Drive edge to the start of the sample cycle.
    localparam int SAMPLE_OFS = 17 + SYNC_ADD;

    logic        clk;
    logic        rst_n;
    logic [7:0]  seg_in;
    logic [3:0]  an_in;
    logic        clr;
    logic [15:0] digits_out;
    logic [3:0]  dp_out;
    logic        frame_valid;
    logic        err;
    logic [1:0]  err_idx;

    seg_scan_capture #(
        .NDIG       (NDIG),
        .STABLE_CYC (16),
        .CNT_W      (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_in      (seg_in),
        .an_in       (an_in),
        .clr         (clr),
        .digits_out  (digits_out),
        .dp_out      (dp_out),
        .frame_valid (frame_valid),
        .err         (err),
        .err_idx     (err_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors    = 0;
    int miscompares = 0;
    int last_drive_cyc = 0;

    logic [19:0] exp_q[$];
    logic [19:0] obs_q[$];
    int          obs_cyc_q[$];

    always @(negedge clk) begin
        if (frame_valid === 1'b1) begin
            obs_q.push_back({digits_out, dp_out});
            obs_cyc_q.push_back(cyc);
        end
    end

    task automatic drive(input logic [3:0] an, input logic [7:0] seg, input int n);
        an_in = an;
        seg_in = seg;
        last_drive_cyc = cyc;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({digits_out, dp_out, frame_valid, err, err_idx} !== 24'h0) begin
            miscompares++;
            $display("FAIL reset_state: got %h required 000000",
                     {digits_out, dp_out, frame_valid, err, err_idx});
        end
        rst_n = 1'b1;
        drive(4'b1111, 8'hFF, 5);
        vectors++;
        if ({digits_out, dp_out, err, err_idx} !== 23'h0 || obs_q.size() != 0) begin
            miscompares++;
            $display("FAIL reset_release: got out=%h frames=%0d required 0/0",
                     {digits_out, dp_out, err, err_idx}, obs_q.size());
        end
    endtask

    task automatic test_basic();
        logic [19:0] e, o;
        int oc, ld;
        exp_q.push_back({16'h9420, 4'b0000});
        drive(4'b1110, 8'hC0, 20);
        drive(4'b1101, 8'hA4, 20);
        drive(4'b1011, 8'h99, 20);
        drive(4'b0111, 8'h90, 20);
        ld = last_drive_cyc;
        drive(4'b1111, 8'hFF, 5);
        vectors++;
        if (obs_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL basic_count: got %0d frames required %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); oc = obs_cyc_q.pop_front();
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL basic_frame: got %h required %h", o, e);
            end
            vectors++;
            if (oc - ld != FRAME_LAT) begin
                miscompares++;
                $display("FAIL basic_latency: got %0d required %0d", oc - ld, FRAME_LAT);
            end
        end
        vectors++;
        if (err !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_err: got %b required 0", err);
        end
        exp_q.delete(); obs_q.delete(); obs_cyc_q.delete();
    endtask

    task automatic test_dp();
        logic [19:0] e, o;
        exp_q.push_back({16'h9410, 4'b0010});
        drive(4'b1110, 8'hC0, 20);
        drive(4'b1101, 8'h79, 20);
        drive(4'b1011, 8'h99, 20);
        drive(4'b0111, 8'h90, 20);
        drive(4'b1111, 8'hFF, 5);
        vectors++;
        if (obs_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL dp_count: got %0d frames required %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL dp_frame: got %h required %h", o, e);
            end
        end
        exp_q.delete(); obs_q.delete(); obs_cyc_q.delete();
    endtask

    task automatic test_back_to_back();
        logic [19:0] e, o;
        exp_q.push_back({16'h8765, 4'b0000});
        drive(4'b1110, 8'h92, 20);
        drive(4'b1101, 8'h82, 20);
        drive(4'b1011, 8'hF8, 20);
        drive(4'b0111, 8'h80, 20);
        exp_q.push_back({16'h3401, 4'b1100});
        drive(4'b0111, 8'h30, 20);
        drive(4'b1011, 8'h19, 20);
        drive(4'b1101, 8'hC0, 20);
        drive(4'b1110, 8'hF9, 20);
        drive(4'b1111, 8'hFF, 5);
        vectors++;
        if (obs_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL b2b_count: got %0d frames required %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL b2b_frame: got %h required %h", o, e);
            end
        end
        exp_q.delete(); obs_q.delete(); obs_cyc_q.delete();
    endtask

    task automatic test_illegal();
        logic [19:0] e, o;
        drive(4'b1110, 8'hC0, 20);
        drive(4'b1101, 8'h7F, 20);
        drive(4'b1011, 8'h99, 20);
        drive(4'b0111, 8'h90, 20);
        drive(4'b1111, 8'hFF, 5);
        vectors++;
        if (err !== 1'b1 || err_idx !== 2'd1) begin
            miscompares++;
            $display("FAIL illegal_err: got err=%b idx=%0d required err=1 idx=1", err, err_idx);
        end
        vectors++;
        if (obs_q.size() != 0) begin
            miscompares++;
            $display("FAIL illegal_noframe: got %0d frames required 0", obs_q.size());
        end
        exp_q.push_back({16'h9420, 4'b0000});
        drive(4'b1101, 8'hA4, 20);
        drive(4'b1111, 8'hFF, 5);
        vectors++;
        if (obs_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL illegal_count: got %0d frames required %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL illegal_frame: got %h required %h", o, e);
            end
        end
        exp_q.delete(); obs_q.delete(); obs_cyc_q.delete();
    endtask

    task automatic test_clr();
        drive(4'b1110, 8'hC0, 20);
        drive(4'b1101, 8'hA4, 20);
        drive(4'b1011, 8'h99, 20);
        an_in = 4'b1111; seg_in = 8'hFF; clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        vectors++;
        if (err !== 1'b0 || err_idx !== 2'd0 || digits_out !== 16'h9420) begin
            miscompares++;
            $display("FAIL clr_state: got err=%b idx=%0d digits=%h required 0/0/9420",
                     err, err_idx, digits_out);
        end
        // Seen mask was cleared, so digit 3 alone must not complete a frame.
        drive(4'b0111, 8'h90, 20);
        drive(4'b1111, 8'hFF, 5);
        vectors++;
        if (obs_q.size() != 0) begin
            miscompares++;
            $display("FAIL clr_seen: got %0d frames required 0", obs_q.size());
        end
        // clr coincident with the completing sample.
        drive(4'b1110, 8'hC0, 20);
        drive(4'b1101, 8'hA4, 20);
        an_in = 4'b1011; seg_in = 8'h99;
        repeat (SAMPLE_OFS) @(posedge clk);
        #1; clr = 1'b1;
        @(posedge clk); #1; clr = 1'b0;
        drive(4'b1011, 8'h99, 3);
        drive(4'b1111, 8'hFF, 5);
        vectors++;
        if (obs_q.size() != 0) begin
            miscompares++;
            $display("FAIL clr_wins: got %0d frames required 0", obs_q.size());
        end
        exp_q.delete(); obs_q.delete(); obs_cyc_q.delete();
    endtask

    task automatic test_stability();
        logic [19:0] e, o;
        drive(4'b1101, 8'hA4, 20);
        drive(4'b1011, 8'h99, 20);
        drive(4'b0111, 8'h90, 20);
        for (int k = 0; k < 6; k++) drive(4'b1110, (k % 2 == 0) ? 8'hC0 : 8'hF9, 10);
        vectors++;
        if (obs_q.size() != 0) begin
            miscompares++;
            $display("FAIL toggle_nosample: got %0d frames required 0", obs_q.size());
        end
        exp_q.push_back({16'h9421, 4'b0000});
        drive(4'b1110, 8'hF9, 40);
        drive(4'b1111, 8'hFF, 5);
        // Boundary: 16 cycles of input stability is one short, 17 is enough.
        drive(4'b1101, 8'hA4, 20);
        drive(4'b1011, 8'h99, 20);
        drive(4'b0111, 8'h90, 20);
        drive(4'b1110, 8'h92, 16);
        drive(4'b1111, 8'hFF, 5);
        vectors++;
        if (obs_q.size() != 1) begin
            miscompares++;
            $display("FAIL stable_short: got %0d frames required 1", obs_q.size());
        end
        exp_q.push_back({16'h9425, 4'b0000});
        drive(4'b1110, 8'h92, 17);
        drive(4'b1111, 8'hFF, 5);
        vectors++;
        if (obs_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL stable_count: got %0d frames required %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL stable_frame: got %h required %h", o, e);
            end
        end
        exp_q.delete(); obs_q.delete(); obs_cyc_q.delete();
    endtask

    task automatic test_idle();
        drive(4'b1100, 8'h7F, 50);
        drive(4'b1111, 8'h7F, 50);
        drive(4'b0000, 8'h7F, 20);
        drive(4'b1111, 8'hFF, 5);
        vectors++;
        if (err !== 1'b0 || obs_q.size() != 0) begin
            miscompares++;
            $display("FAIL idle_nosample: got err=%b frames=%0d required 0/0", err, obs_q.size());
        end
        exp_q.delete(); obs_q.delete(); obs_cyc_q.delete();
    endtask

    task automatic test_reset_mid();
        drive(4'b1110, 8'hC0, 20);
        drive(4'b1101, 8'hA4, 20);
        drive(4'b1011, 8'h99, 20);
        an_in = 4'b1111; seg_in = 8'hFF;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({digits_out, dp_out, frame_valid, err, err_idx} !== 24'h0) begin
            miscompares++;
            $display("FAIL midreset_state: got %h required 000000",
                     {digits_out, dp_out, frame_valid, err, err_idx});
        end
        rst_n = 1'b1;
        drive(4'b0111, 8'h90, 20);
        drive(4'b1111, 8'hFF, 5);
        vectors++;
        if (obs_q.size() != 0 || digits_out !== 16'h0 || dp_out !== 4'h0) begin
            miscompares++;
            $display("FAIL midreset_noframe: got frames=%0d digits=%h dp=%h required 0/0000/0",
                     obs_q.size(), digits_out, dp_out);
        end
        exp_q.delete(); obs_q.delete(); obs_cyc_q.delete();
    endtask

    initial begin
        rst_n  = 1'b0;
        clr    = 1'b0;
        an_in  = 4'b1111;
        seg_in = 8'hFF;
        test_reset();
        test_basic();
        test_dp();
        test_back_to_back();
        test_illegal();
        test_clr();
        test_stability();
        test_idle();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
